// File: rtl/uart_seq_if.sv
// Client byte streams plus the uart register port, bundled for the uart_seq sequencer.
// Handshake: a byte moves on a rising clk edge where valid && ready; the sender holds data stable while valid is high.
interface uart_seq_if #(
    parameter int WIDTH = 32
);
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic             u_cs;
    logic             u_wen;
    logic [3:0]       u_addr;
    logic [WIDTH-1:0] u_din;
    logic [WIDTH-1:0] u_dout;

    modport master (
        input  tx_valid, tx_data, rx_ready, u_dout,
        output tx_ready, rx_valid, rx_data, u_cs, u_wen, u_addr, u_din
    );

    modport slave (
        output tx_valid, tx_data, rx_ready, u_dout,
        input  tx_ready, rx_valid, rx_data, u_cs, u_wen, u_addr, u_din
    );
endinterface

// File: rtl/uart_seq.sv
// Autonomous uart register-bus master: configures the uart, then time-shares its
// register port between draining a TX byte queue and delivering received bytes.
module uart_seq #(
    parameter int WIDTH    = 32,
    parameter int CPB_INIT = 217,
    parameter int TXQ_AW   = 4
) (
    input  logic       clk,
    input  logic       reset,
    uart_seq_if.master bus,
    output logic       o_init_done,
    output logic [3:0] o_dbg_state,
    output logic       o_dbg_last_svc
);
    localparam int TXQ_DEPTH = 1 << TXQ_AW;
    localparam logic [TXQ_AW:0] TXQ_FULL = (TXQ_AW+1)'(TXQ_DEPTH);

    localparam logic [3:0] ADDR_DR    = 4'd0;
    localparam logic [3:0] ADDR_CTRL  = 4'd1;
    localparam logic [3:0] ADDR_RSTAT = 4'd2;
    localparam logic [3:0] ADDR_TSTAT = 4'd3;
    localparam logic [3:0] ADDR_CPB   = 4'd4;
    localparam logic [3:0] ADDR_RXPOP = 4'd6;

    localparam logic SVC_RX = 1'b0;
    localparam logic SVC_TX = 1'b1;

    typedef enum logic [3:0] {
        S_INIT_CPB,
        S_INIT_CTRL,
        S_IDLE,
        S_TX_POLL,
        S_TX_WRITE,
        S_TX_GUARD1,
        S_TX_GUARD2,
        S_RX_POLL,
        S_RX_READ,
        S_RX_POP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]        r_txq [TXQ_DEPTH];
    logic [TXQ_AW-1:0] r_wr_ptr;
    logic [TXQ_AW-1:0] r_rd_ptr;
    logic [TXQ_AW:0]   r_count;

    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic       r_last_svc;
    logic       r_init_done;

    logic             w_full;
    logic             w_empty;
    logic             w_tx_ready;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_head;
    logic             w_cs;
    logic             w_wen;
    logic [3:0]       w_addr;
    logic [WIDTH-1:0] w_din;
    logic             w_dout_unused;

    assign w_full     = (r_count == TXQ_FULL);
    assign w_empty    = (r_count == '0);
    assign w_tx_ready = ~w_full & ~reset;
    assign w_push     = bus.tx_valid & w_tx_ready;
    assign w_pop      = (r_state == S_TX_WRITE) & ~w_empty;
    assign w_head     = r_txq[r_rd_ptr];

    assign w_dout_unused = ^bus.u_dout[WIDTH-1:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT_CPB;
        end else begin
            r_state <= w_next;
        end
    end

    // Bus signals are a pure decode of the state, so every bus state lasts one cycle.
    always_comb begin
        w_next = r_state;
        w_cs   = 1'b0;
        w_wen  = 1'b0;
        w_addr = '0;
        w_din  = '0;
        case (r_state)
            S_INIT_CPB: begin
                w_cs   = 1'b1;
                w_wen  = 1'b1;
                w_addr = ADDR_CPB;
                w_din  = WIDTH'(CPB_INIT);
                w_next = S_INIT_CTRL;
            end
            S_INIT_CTRL: begin
                w_cs   = 1'b1;
                w_wen  = 1'b1;
                w_addr = ADDR_CTRL;
                w_din  = WIDTH'(3);
                w_next = S_IDLE;
            end
            S_IDLE: begin
                // A held rx byte blocks RX service, so TX may go even after TX was last served.
                if (!w_empty && (r_last_svc == SVC_RX || r_rx_valid)) begin
                    w_next = S_TX_POLL;
                end else if (!r_rx_valid) begin
                    w_next = S_RX_POLL;
                end
            end
            S_TX_POLL: begin
                w_cs   = 1'b1;
                w_addr = ADDR_TSTAT;
                w_next = bus.u_dout[0] ? S_TX_WRITE : S_IDLE;
            end
            S_TX_WRITE: begin
                w_cs   = 1'b1;
                w_wen  = 1'b1;
                w_addr = ADDR_DR;
                w_din  = {{(WIDTH-8){1'b0}}, w_head};
                w_next = S_TX_GUARD1;
            end
            S_TX_GUARD1: w_next = S_TX_GUARD2;
            S_TX_GUARD2: w_next = S_IDLE;
            S_RX_POLL: begin
                w_cs   = 1'b1;
                w_addr = ADDR_RSTAT;
                w_next = bus.u_dout[0] ? S_RX_READ : S_IDLE;
            end
            S_RX_READ: begin
                w_cs   = 1'b1;
                w_addr = ADDR_DR;
                w_next = S_RX_POP;
            end
            S_RX_POP: begin
                w_cs   = 1'b1;
                w_wen  = 1'b1;
                w_addr = ADDR_RXPOP;
                w_next = S_IDLE;
            end
            default: w_next = S_INIT_CPB;
        endcase
    end

    assign bus.u_cs   = w_cs & ~reset;
    assign bus.u_wen  = w_wen & ~reset;
    assign bus.u_addr = reset ? '0 : w_addr;
    assign bus.u_din  = reset ? '0 : w_din;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_txq[r_wr_ptr] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + TXQ_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + TXQ_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (TXQ_AW+1)'(1);
                2'b01:   r_count <= r_count - (TXQ_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
            r_last_svc  <= SVC_RX;
            r_init_done <= 1'b0;
        end else begin
            if (r_state == S_INIT_CTRL) begin
                r_init_done <= 1'b1;
            end
            if (r_state == S_TX_POLL) begin
                r_last_svc <= SVC_TX;
            end else if (r_state == S_RX_POLL) begin
                r_last_svc <= SVC_RX;
            end
            if (r_state == S_RX_READ) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= bus.u_dout[7:0];
            end else if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus.tx_ready   = w_tx_ready;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.rx_data    = r_rx_data;
    assign o_init_done    = r_init_done;
    assign o_dbg_state    = r_state;
    assign o_dbg_last_svc = r_last_svc;
endmodule

// File: tb/tb_uart_seq.sv
// Bench for uart_seq: a transaction-level uart/client model scores every bus cycle,
// while directed scenarios pin init, TX ordering, RX backpressure, queue wrap and reset abort.
module tb_uart_seq;
    localparam int WIDTH = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_done;
    logic [3:0] dbg_state;
    logic       dbg_last_svc;

    always #5 clk = ~clk;

    uart_seq_if #(.WIDTH(WIDTH)) bus ();

    uart_seq #(.WIDTH(WIDTH), .CPB_INIT(217), .TXQ_AW(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .o_init_done    (init_done),
        .o_dbg_state    (dbg_state),
        .o_dbg_last_svc (dbg_last_svc)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Uart model: TX status is set by the scenarios, RX fifo is a queue.
    logic       tstat;
    logic       rx_nonempty;
    logic [7:0] rx_head;
    logic [7:0] uart_rx_q [$];

    assign bus.u_dout = (bus.u_addr == 4'd3) ? {31'b0, tstat} :
                        (bus.u_addr == 4'd2) ? {31'b0, rx_nonempty} :
                        (bus.u_addr == 4'd0) ? {24'b0, rx_head} : 32'b0;

    // Client-side expectations.
    logic [7:0] exp_tx_q [$];
    logic [7:0] exp_rx_q [$];
    logic [7:0] last_rx;
    logic [7:0] w0_din_q [$];
    int         w0_cyc_q [$];
    int         cyc = 0;
    int         cyc_since_rst = 0;
    int         guard_cnt = 0;
    int         w0_cnt = 0;
    int         w6_cnt = 0;
    int         tpoll_cnt = 0;
    int         rpoll_cnt = 0;
    bit         rst_prev = 0;
    bit         prev_tpoll_ok = 0;
    bit         prev_rpoll_ok = 0;
    bit         prev_rx_read = 0;
    bit         expect_rxv0 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void refresh_uart();
        rx_nonempty = (uart_rx_q.size() != 0);
        rx_head     = rx_nonempty ? uart_rx_q[0] : 8'h00;
    endfunction

    // Scoreboard: runs every cycle at the falling edge.
    always @(negedge clk) begin
        logic wr;
        logic rd;
        logic [7:0] b;
        cyc++;
        wr = bus.u_cs & bus.u_wen;
        rd = bus.u_cs & ~bus.u_wen;
        if (reset) begin
            check("rst_u_cs", bus.u_cs, 0);
            check("rst_u_wen", bus.u_wen, 0);
            check("rst_u_addr", bus.u_addr, 0);
            check("rst_u_din", bus.u_din, 0);
            check("rst_tx_ready", bus.tx_ready, 0);
            if (rst_prev) begin
                check("rst_rx_valid", bus.rx_valid, 0);
                check("rst_rx_data", bus.rx_data, 0);
                check("rst_init_done", init_done, 0);
                check("rst_last_svc_rx", dbg_last_svc, 0);
            end
            exp_tx_q.delete();
            last_rx       = 8'h00;
            cyc_since_rst = 0;
            guard_cnt     = 0;
            prev_tpoll_ok = 0;
            prev_rpoll_ok = 0;
            prev_rx_read  = 0;
            expect_rxv0   = 0;
            rst_prev      = 1;
        end else begin
            rst_prev = 0;
            cyc_since_rst++;
            check("tx_ready", bus.tx_ready, exp_tx_q.size() < 16);
            check("init_done", init_done, cyc_since_rst >= 3);
            if (bus.u_wen) check("wen_implies_cs", bus.u_cs, 1);
            if (guard_cnt > 0) begin
                check("guard_idle", bus.u_cs, 0);
                guard_cnt--;
            end

            if (expect_rxv0) check("rx_valid_clear", bus.rx_valid, 0);
            expect_rxv0 = 0;
            if (bus.rx_valid) begin
                check("rx_has_expected", exp_rx_q.size() != 0, 1);
                if (exp_rx_q.size() != 0) begin
                    check("rx_data", bus.rx_data, exp_rx_q[0]);
                    if (bus.rx_ready) begin
                        last_rx     = exp_rx_q.pop_front();
                        expect_rxv0 = 1;
                    end
                end
            end else begin
                check("rx_data_hold", bus.rx_data, last_rx);
            end

            if (cyc_since_rst == 1) begin
                check("init_cpb_write", {wr, bus.u_addr, bus.u_din}, {1'b1, 4'd4, 32'd217});
            end else if (cyc_since_rst == 2) begin
                check("init_ctrl_write", {wr, bus.u_addr, bus.u_din}, {1'b1, 4'd1, 32'd3});
            end else if (wr) begin
                check("write_addr_legal", bus.u_addr inside {4'd0, 4'd6}, 1);
                if (bus.u_addr == 4'd0) begin
                    w0_cnt++;
                    check("tx_write_after_idle_poll", prev_tpoll_ok, 1);
                    check("tx_write_expected", exp_tx_q.size() != 0, 1);
                    if (exp_tx_q.size() != 0) begin
                        b = exp_tx_q.pop_front();
                        check("tx_write_din", bus.u_din, {24'b0, b});
                    end
                    w0_din_q.push_back(bus.u_din[7:0]);
                    w0_cyc_q.push_back(cyc);
                    guard_cnt = 3;
                end else if (bus.u_addr == 4'd6) begin
                    w6_cnt++;
                    check("rx_pop_after_read", prev_rx_read, 1);
                    check("rx_pop_din", bus.u_din, 0);
                    check("rx_pop_valid", bus.rx_valid, 1);
                    if (uart_rx_q.size() != 0) void'(uart_rx_q.pop_front());
                end
            end else if (rd) begin
                check("read_addr_legal", bus.u_addr inside {4'd0, 4'd2, 4'd3}, 1);
                check("read_din_zero", bus.u_din, 0);
                if (bus.u_addr == 4'd3) tpoll_cnt++;
                if (bus.u_addr == 4'd2) begin
                    rpoll_cnt++;
                    check("rx_poll_while_valid", bus.rx_valid, 0);
                end
                if (bus.u_addr == 4'd0) check("rx_read_after_poll", prev_rpoll_ok, 1);
            end
            prev_tpoll_ok = rd && bus.u_addr == 4'd3 && tstat;
            prev_rpoll_ok = rd && bus.u_addr == 4'd2 && rx_nonempty;
            prev_rx_read  = rd && bus.u_addr == 4'd0;
            refresh_uart();
            if (bus.tx_valid && bus.tx_ready) exp_tx_q.push_back(bus.tx_data);
        end
    end

    // Driver tasks: inputs change 1ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic to_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input int limit, output bit ok);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (bus.tx_ready) ok = 1;
            to_edge();
        end
        bus.tx_valid = 1'b0;
    endtask

    task automatic push_checked(input logic [7:0] b, input int limit);
        bit ok;
        push_byte(b, limit, ok);
        check("push_accepted", ok, 1);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && exp_tx_q.size() != 0; i++) tick();
        check("tx_drained", exp_tx_q.size(), 0);
        repeat (4) tick();
        to_edge();
    endtask

    task automatic inject_rx(input logic [7:0] b);
        uart_rx_q.push_back(b);
        exp_rx_q.push_back(b);
        refresh_uart();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_w0;
        int base_tp;
        int base_rp;
        int base_w6;
        bit seen;
        reset        = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.rx_ready = 1'b0;
        tstat        = 1'b0;
        refresh_uart();

        // Init sequence: CPB write, CTRL write, then init_done.
        do_reset(3);
        repeat (3) tick();
        check("init_done_cycle3", init_done, 1);
        to_edge();

        // Two bytes with the uart TX idle: 0x41 then 0x42, seven cycles apart.
        tstat = 1'b1;
        w0_din_q.delete();
        w0_cyc_q.delete();
        push_checked(8'h41, 10);
        push_checked(8'h42, 10);
        wait_drain(60);
        check("t2_write_count", w0_din_q.size(), 2);
        if (w0_din_q.size() == 2) begin
            check("t2_first_byte", w0_din_q[0], 8'h41);
            check("t2_second_byte", w0_din_q[1], 8'h42);
            check("t2_write_spacing", w0_cyc_q[1] - w0_cyc_q[0], 7);
        end
        check("t2_queue_empty_ready", bus.tx_ready, 1);

        // Busy uart: polls alternate TX/RX and no data write happens.
        tstat   = 1'b0;
        base_w0 = w0_cnt;
        base_tp = tpoll_cnt;
        base_rp = rpoll_cnt;
        push_checked(8'h33, 10);
        repeat (10) tick();
        check("t3_no_write_while_busy", w0_cnt - base_w0, 0);
        check("t3_tx_polls", (tpoll_cnt - base_tp) >= 2, 1);
        check("t3_rx_polls", (rpoll_cnt - base_rp) >= 2, 1);
        to_edge();
        tstat = 1'b1;
        wait_drain(40);
        check("t3_byte_sent", w0_din_q[w0_din_q.size()-1], 8'h33);

        // RX byte 0x5A with the client stalled.
        base_w6 = w6_cnt;
        inject_rx(8'h5A);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (bus.rx_valid) seen = 1;
        end
        check("t4_rx_valid_seen", seen, 1);
        check("t4_rx_data_5a", bus.rx_data, 8'h5A);
        base_rp = rpoll_cnt;
        repeat (20) tick();
        check("t4_single_pop", w6_cnt - base_w6, 1);
        check("t4_no_rx_poll_while_held", rpoll_cnt - base_rp, 0);
        check("t4_still_valid", bus.rx_valid, 1);
        to_edge();
        bus.rx_ready = 1'b1;
        to_edge();
        bus.rx_ready = 1'b0;
        tick();
        check("t4_valid_cleared", bus.rx_valid, 0);
        check("t4_data_held", bus.rx_data, 8'h5A);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (rpoll_cnt != base_rp) seen = 1;
        end
        check("t4_rx_poll_resumes", seen, 1);
        to_edge();

        // 17 bytes against a busy uart: 16 fill the queue, the 17th waits, all emerge in order.
        tstat = 1'b0;
        w0_din_q.delete();
        for (int i = 0; i < 16; i++) push_checked(8'h10 + 8'(i), 10);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h20;
        repeat (6) begin
            @(negedge clk);
            check("t5_full_holds_17th", bus.tx_ready, 0);
        end
        to_edge();
        tstat = 1'b1;
        push_checked(8'h20, 60);
        wait_drain(400);
        check("t5_write_count", w0_din_q.size(), 17);
        if (w0_din_q.size() == 17) begin
            check("t5_first", w0_din_q[0], 8'h10);
            check("t5_wrap_16th", w0_din_q[15], 8'h1F);
            check("t5_wrap_17th", w0_din_q[16], 8'h20);
        end

        // Reset in the guard after the first of six bytes: the other five are dropped.
        tstat = 1'b0;
        for (int i = 0; i < 6; i++) push_checked(8'h60 + 8'(i), 10);
        base_w0 = w0_cnt;
        tstat = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (w0_cnt != base_w0) seen = 1;
        end
        check("t6_first_write_seen", seen, 1);
        to_edge();
        reset = 1'b1;
        @(negedge clk);
        check("t6_cs_low_in_reset", bus.u_cs, 0);
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        base_w0 = w0_cnt;
        repeat (3) tick();
        check("t6_init_done_again", init_done, 1);
        repeat (60) tick();
        check("t6_no_stale_bytes", w0_cnt - base_w0, 0);
        check("t6_queue_empty", bus.tx_ready, 1);
        to_edge();
        push_checked(8'h77, 10);
        wait_drain(40);
        check("t6_fresh_byte", w0_din_q[w0_din_q.size()-1], 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
